// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller driving the instruction
// memory / IR block. It walks FETCH -> LOAD -> ISSUE per instruction, hands
// the latched instruction to decode over a valid/ready handshake, then
// advances the PC sequentially (modulo 2^PC_WIDTH) or to a branch target.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the 32-bit
// accepted-instruction counter on fetch_count; otherwise fetch_count is 0.

module fetch_sequencer #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                run,
  input  logic                dec_ready,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] program_counter,
  output logic                loadIR,
  output logic                ir_valid,
  output logic                halted,
  output logic [31:0]         fetch_count
);

  // HALT uses the third state bit; the four working states keep the 2-bit codes.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state, next_state;
  logic   accept;

  // A handshake completes when the IR is presented and decode takes it.
  assign accept = (state == ISSUE) && dec_ready;

  // State register; reset drops any in-flight instruction back to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      // NOTE: flops use non-blocking assignment so every register samples
      // pre-edge values regardless of block ordering.
      state <= next_state;
    end
  end

  // Next-state logic; run only gates the IDLE exit and the post-accept choice,
  // so dropping it mid-instruction lets that instruction finish.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:    if (run) next_state = FETCH;
      FETCH:   next_state = LOAD;
      LOAD:    next_state = ISSUE;
      ISSUE: begin
        if (accept) begin
          if (halt_req) next_state = HALT;
          else if (run) next_state = FETCH;
          else          next_state = IDLE;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded straight from the state flops.
  always_comb begin
    loadIR   = 1'b0;
    ir_valid = 1'b0;
    halted   = 1'b0;
    unique case (state)
      LOAD:    loadIR   = 1'b1;
      ISSUE:   ir_valid = 1'b1;
      HALT:    halted   = 1'b1;
      default: ;
    endcase
  end

  // PC register: only an accept moves it, so IDLE, stalls and HALT hold it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      program_counter <= RESET_PC;
    end else if (accept) begin
      if (branch_valid) program_counter <= branch_target;
      else              program_counter <= program_counter + PC_WIDTH'(1);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Accepted-instruction counter; free-running wrap, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_count <= 32'h0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, decode stall, branch,
// PC wrap, run drop to IDLE, combined branch+halt, reset mid-LOAD and the
// optional accept counter. Inputs are driven and outputs sampled at negedge.

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        run = 1'b0;
  logic        dec_ready = 1'b0;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        halt_req = 1'b0;
  logic [15:0] program_counter;
  logic        loadIR;
  logic        ir_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .run             (run),
    .dec_ready       (dec_ready),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .halt_req        (halt_req),
    .program_counter (program_counter),
    .loadIR          (loadIR),
    .ir_valid        (ir_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef FETCH_PERF_CNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  task automatic expect_out(input string tag, input logic [15:0] pc, input logic ld,
                            input logic iv, input logic hl);
    check({tag, ".pc"},       {16'h0, program_counter}, {16'h0, pc});
    check({tag, ".loadIR"},   {31'h0, loadIR},          {31'h0, ld});
    check({tag, ".ir_valid"}, {31'h0, ir_valid},        {31'h0, iv});
    check({tag, ".halted"},   {31'h0, halted},          {31'h0, hl});
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset.
    cyc();
    cyc();
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("reset.count", fetch_count, 32'h0);

    // Sequential fetch: cycle k counts edges after the IDLE->FETCH edge.
    rstn      = 1'b1;
    run       = 1'b1;
    dec_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      expect_out($sformatf("seq%0d", k), 16'((k - 1) / 3), (k % 3) == 2, (k % 3) == 0, 1'b0);
      if (k == 9) dec_ready = 1'b0;
    end

    // Decode stall for 4 cycles in ISSUE at PC 2.
    for (int s = 0; s < 4; s++) begin
      cyc();
      expect_out($sformatf("stall%0d", s), 16'h0002, 1'b0, 1'b1, 1'b0);
    end
    dec_ready = 1'b1;
    cyc();                                        // 14: FETCH
    expect_out("post_stall", 16'h0003, 1'b0, 1'b0, 1'b0);

    // Branch at PC 3 to 0x0040.
    cyc();                                        // 15: LOAD
    cyc();                                        // 16: ISSUE
    expect_out("br_issue", 16'h0003, 1'b0, 1'b1, 1'b0);
    branch_valid  = 1'b1;
    branch_target = 16'h0040;
    cyc();                                        // 17: FETCH
    expect_out("br_taken", 16'h0040, 1'b0, 1'b0, 1'b0);

    // Branch to 0xFFFF, then wrap on a sequential accept.
    branch_target = 16'hFFFF;
    cyc();                                        // 18: LOAD
    cyc();                                        // 19: ISSUE
    cyc();                                        // 20: FETCH
    expect_out("to_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    branch_valid = 1'b0;
    cyc();                                        // 21: LOAD
    cyc();                                        // 22: ISSUE
    cyc();                                        // 23: FETCH
    expect_out("wrap", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Drop run during FETCH: instruction completes, then IDLE with PC held.
    run = 1'b0;
    cyc();                                        // 24: LOAD
    expect_out("rundrop_load", 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc();                                        // 25: ISSUE
    cyc();                                        // 26: IDLE
    expect_out("idle0", 16'h0001, 1'b0, 1'b0, 1'b0);
    cyc();                                        // 27: IDLE
    expect_out("idle1", 16'h0001, 1'b0, 1'b0, 1'b0);
    run = 1'b1;
    cyc();                                        // 28: FETCH, resumes at held PC
    expect_out("resume", 16'h0001, 1'b0, 1'b0, 1'b0);

    // Combined branch and halt.
    cyc();                                        // 29: LOAD
    cyc();                                        // 30: ISSUE
    halt_req      = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 16'h0010;
    cyc();                                        // 31: HALT
    expect_out("halt", 16'h0010, 1'b0, 1'b0, 1'b1);
    check("halt.count", fetch_count, cnt_exp(8));
    halt_req     = 1'b0;
    branch_valid = 1'b0;
    for (int h = 0; h < 3; h++) begin
      cyc();
      expect_out($sformatf("halt_hold%0d", h), 16'h0010, 1'b0, 1'b0, 1'b1);
    end

    // Reset is the only way out of HALT.
    rstn = 1'b0;
    #1;
    expect_out("halt_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("halt_reset.count", fetch_count, 32'h0);
    cyc();
    rstn = 1'b1;
    cyc();                                        // 1: FETCH
    cyc();                                        // 2: LOAD
    expect_out("pre_mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of LOAD.
    rstn = 1'b0;
    #1;
    expect_out("mid_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc();
    expect_out("mid_reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Restart from 0 and complete 5 accepts.
    for (int k = 1; k <= 15; k++) begin
      cyc();
      expect_out($sformatf("restart%0d", k), 16'((k - 1) / 3), (k % 3) == 2, (k % 3) == 0, 1'b0);
    end
    cyc();                                        // 16: FETCH
    expect_out("restart_end", 16'h0005, 1'b0, 1'b0, 1'b0);
    check("perf_count", fetch_count, cnt_exp(5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
